// File: rtl/data_mem_responder.sv
// Single-port data memory behind a valid/ready request/response handshake.
// Accepts byte/half/word loads and stores and answers after a fixed wait-state delay.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q;
    logic [AW+1:0] addr_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [31:0]   wdata_q;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_error_q, rsp_error_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          req_err;
    logic          access;
    logic [3:0]    be;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   ld_data;

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid && req_ready;
    assign access    = (state_q == StWait) && (cnt_q == 4'd0);

    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;

    // Any address bit above the word index makes the request out of range.
    always_comb begin
        req_err = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
               || ((req_addr >> (AW + 2)) != '0);
    end

    always_comb begin
        case (size_q)
            2'b00:   begin
                be      = 4'b0001 << addr_q[1:0];
                wr_data = {4{wdata_q[7:0]}};
            end
            2'b01:   begin
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
    end

    always_comb begin
        rd_word  = mem[addr_q[AW+1:2]];
        rd_shift = rd_word >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   ld_data = uns_q ? {24'b0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   ld_data = uns_q ? {16'b0, rd_shift[15:0]}
                                     : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = wr_q ? '0 : ld_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr[AW+1:0];
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
            end
        end
    end

    // Storage has no reset; an aborted store never reaches this block because state_q is forced idle.
    always_ff @(posedge clk) begin
        if (access && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder with directed scenarios and a byte-array reference model.
module tb_data_mem_responder;

    localparam int unsigned WS    = 2;
    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference contents of words 0..63 (byte addresses 0x00..0xFF).
    logic [31:0] mm [64];

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_op(input logic w, input logic [31:0] a, input logic [1:0] sz,
                                     input logic u, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er);
        int unsigned nb;
        int unsigned sh;
        logic [31:0] mask;
        logic [31:0] v;
        er = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
          || (a >= 4 * DEPTH);
        rd = '0;
        if (er) return;
        nb   = 1 << sz;
        sh   = 8 * (a % 4);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        if (w) begin
            mm[a[7:2]] = (mm[a[7:2]] & ~(mask << sh)) | ((wd & mask) << sh);
        end else begin
            v = (mm[a[7:2]] >> sh) & mask;
            if (!u && nb < 4 && v[8*nb-1]) v = v | ~mask;
            rd = v;
        end
    endfunction

    task automatic accept_req(input logic w, input logic [31:0] a, input logic [1:0] sz,
                              input logic u, input logic [31:0] wd, input bit noise);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            tests_run++;
            tests_failed++;
            $display("FAIL accept_timeout: req_ready=%b, required 1", req_ready);
        end
        req_valid    = 1'b1;
        req_write    = w;
        req_addr     = a;
        req_size     = sz;
        req_unsigned = u;
        req_wdata    = wd;
        @(posedge clk); #1;
        if (noise) begin
            req_valid    = 1'($urandom);
            req_write    = 1'($urandom);
            req_addr     = $urandom;
            req_size     = 2'($urandom);
            req_unsigned = 1'($urandom);
            req_wdata    = $urandom;
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (rsp_valid !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL rsp_timeout: rsp_valid=%b, required 1", rsp_valid);
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, input bit noise,
                        output logic [31:0] rd, output logic er, output int lat);
        accept_req(w, a, sz, u, wd, noise);
        wait_rsp(lat);
        rd = rsp_rdata;
        er = rsp_error;
        consume();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b err=%b rdata=%h, required 0 0 00000000",
                     rsp_valid, rsp_error, rsp_rdata);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd;
        logic er;
        int lat;
        xact(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1, rd, er, lat);
        tests_run++;
        if (lat != 4 || er !== 1'b0 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL word_store: lat=%0d err=%b rdata=%h, required 4 0 00000000",
                     lat, er, rd);
        end
        xact(1'b0, 32'h10, 2'b10, 1'b1, 32'h0, 1'b1, rd, er, lat);
        tests_run++;
        if (lat != 4 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL word_load: lat=%0d err=%b rdata=%h, required 4 0 deadbeef",
                     lat, er, rd);
        end
    endtask

    task automatic test_byte_sign();
        logic [31:0] rd;
        logic er;
        int lat;
        logic [31:0] exp [4];
        logic [31:0] addrs [4];
        logic [1:0]  sizes [4];
        logic        unss [4];
        xact(1'b1, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0, rd, er, lat);
        xact(1'b1, 32'h13, 2'b00, 1'b0, 32'hABCDEF80, 1'b1, rd, er, lat);
        addrs = '{32'h10, 32'h13, 32'h13, 32'h12};
        sizes = '{2'b10, 2'b00, 2'b00, 2'b01};
        unss  = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp   = '{32'h80000000, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8000};
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, addrs[i], sizes[i], unss[i], 32'h0, 1'b1, rd, er, lat);
            tests_run++;
            if (rd !== exp[i] || er !== 1'b0) begin
                tests_failed++;
                $display("FAIL byte_sign[%0d]: rdata=%h err=%b, required %h 0",
                         i, rd, er, exp[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er;
        int lat;
        xact(1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, 1'b0, rd, er, lat);
        xact(1'b0, 32'h21, 2'b01, 1'b0, 32'h0, 1'b1, rd, er, lat);
        tests_run++;
        if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
            tests_failed++;
            $display("FAIL misaligned_half: err=%b rdata=%h lat=%0d, required 1 00000000 1",
                     er, rd, lat);
        end
        xact(1'b1, 32'h21, 2'b01, 1'b0, 32'hFFFF, 1'b1, rd, er, lat);
        xact(1'b1, 32'h22, 2'b10, 1'b0, 32'hFFFFFFFF, 1'b1, rd, er, lat);
        xact(1'b1, 32'h20, 2'b11, 1'b0, 32'hFFFFFFFF, 1'b1, rd, er, lat);
        tests_run++;
        if (er !== 1'b1 || lat != 1) begin
            tests_failed++;
            $display("FAIL reserved_size: err=%b lat=%0d, required 1 1", er, lat);
        end
        xact(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b1, rd, er, lat);
        tests_run++;
        if (rd !== 32'h11223344 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_no_write: rdata=%h err=%b, required 11223344 0", rd, er);
        end
        xact(1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, 1'b1, rd, er, lat);
        tests_run++;
        if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
            tests_failed++;
            $display("FAIL out_of_range: err=%b rdata=%h lat=%0d, required 1 00000000 1",
                     er, rd, lat);
        end
        xact(1'b0, 32'hFFC, 2'b10, 1'b0, 32'h0, 1'b1, rd, er, lat);
        tests_run++;
        if (er !== 1'b0 || lat != 4) begin
            tests_failed++;
            $display("FAIL last_word: err=%b lat=%0d, required 0 4", er, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] v;
        int lat;
        logic [31:0] rd;
        logic er;
        v = $urandom;
        xact(1'b1, 32'h30, 2'b10, 1'b0, v, 1'b0, rd, er, lat);
        accept_req(1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 1'b1);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== v || req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure[%0d]: valid=%b rdata=%h ready=%b, required 1 %h 0",
                         i, rsp_valid, rsp_rdata, req_ready, v);
            end
        end
        consume();
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_consume: req_ready=%b rsp_valid=%b, required 1 0",
                     req_ready, rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic er;
        int lat;
        logic [31:0] exp [4];
        for (int i = 0; i < 4; i++) begin
            exp[i] = $urandom;
            xact(1'b1, 32'h80 + 32'(4 * i), 2'b10, 1'b0, exp[i], 1'b1, rd, er, lat);
        end
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, 32'h80 + 32'(4 * i), 2'b10, 1'b0, 32'h0, 1'b1, rd, er, lat);
            tests_run++;
            if (rd !== exp[i] || lat != 4 || er !== 1'b0) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: rdata=%h lat=%0d err=%b, required %h 4 0",
                         i, rd, lat, er, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic er;
        int lat;
        xact(1'b1, 32'h40, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, rd, er, lat);
        accept_req(1'b1, 32'h40, 2'b10, 1'b0, 32'h12345678, 1'b0);
        reset = 1'b1;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0
            || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid: valid=%b err=%b rdata=%h ready=%b, required 0 0 0 1",
                     rsp_valid, rsp_error, rsp_rdata, req_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        xact(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 1'b0, rd, er, lat);
        tests_run++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL aborted_store: rdata=%h err=%b, required cafef00d 0", rd, er);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic er;
        int lat;
        logic        w;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_er;
        int          hold;
        for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            model_op(1'b1, 32'(4 * i), 2'b10, 1'b0, wd, exp_rd, exp_er);
            xact(1'b1, 32'(4 * i), 2'b10, 1'b0, wd, 1'b1, rd, er, lat);
        end
        for (int i = 0; i < 150; i++) begin
            w  = 1'($urandom);
            sz = 2'($urandom);
            u  = 1'($urandom);
            wd = $urandom;
            a  = ($urandom_range(0, 9) == 0) ? (32'h1000 + 32'($urandom_range(0, 4095)))
                                             : 32'($urandom_range(0, 255));
            hold = $urandom_range(0, 3);
            model_op(w, a, sz, u, wd, exp_rd, exp_er);
            accept_req(w, a, sz, u, wd, 1'b1);
            wait_rsp(lat);
            rd = rsp_rdata;
            er = rsp_error;
            repeat (hold) begin
                @(posedge clk); #1;
            end
            tests_run++;
            if (rsp_rdata !== exp_rd || rsp_error !== exp_er || rd !== exp_rd
                || lat != (exp_er ? 1 : WS + 2)) begin
                tests_failed++;
                $display("FAIL random[%0d] w=%b a=%h sz=%0d u=%b: rdata=%h err=%b lat=%0d, required %h %b %0d",
                         i, w, a, sz, u, rsp_rdata, rsp_error, lat, exp_rd, exp_er,
                         exp_er ? 1 : WS + 2);
            end
            consume();
        end
    endtask

    initial begin
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_size     = '0;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;
        test_reset();
        test_word_store_load();
        test_byte_sign();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words of storage, a power of two.
REQ-002 The module SHALL have parameter WAIT_STATES, default 2: the number of extra cycles between request acceptance and the memory access, range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator accepts the response.
REQ-014 rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-015 rsp_error  output  1  request was misaligned, out of range, or used a reserved size.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE, and SHALL be combinational on state only.
REQ-018 A request SHALL be accepted in a cycle where req_valid and req_ready are both 1; on acceptance the module SHALL capture write, addr, size, unsigned and wdata.
REQ-019 An accepted request SHALL be an error when any of these holds: size=11; size=01 with addr[0]≠0; size=10 with addr[1:0]≠0; addr ≥ 4*DEPTH_WORDS.
REQ-020 For an error request, the FSM SHALL go IDLE→RESP on acceptance, with rsp_error=1 and rsp_rdata=0, and SHALL NOT access memory.
REQ-021 For a valid request, the FSM SHALL go IDLE→WAIT and load a countdown with WAIT_STATES.
REQ-022 In WAIT, the counter SHALL decrement each cycle. When the counter is 0, the memory access SHALL occur in that cycle and the FSM SHALL go to RESP.
REQ-023 With WAIT_STATES=0, the access SHALL occur in the first WAIT cycle, so rsp_valid rises 2 cycles after acceptance; in general the latency is WAIT_STATES+2 cycles.
REQ-024 Stores SHALL write only the addressed lanes: byte → lane addr[1:0]; half → lanes {addr[1],0} and {addr[1],1}; word → all four lanes. Stores SHALL write wdata low bits into those lanes.
REQ-025 Loads SHALL select the same lanes, shift the result to bit 0, and extend it per req_unsigned. Word loads SHALL ignore req_unsigned.
REQ-026 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-027 In RESP, rsp_valid, rsp_rdata and rsp_error SHALL be registered and stable until the cycle where rsp_ready=1; the FSM SHALL then return to IDLE.
REQ-028 No request SHALL be accepted in the cycle the response is consumed; the next acceptance is possible the following cycle at the earliest.
REQ-029 rsp_ready asserted outside RESP SHALL be ignored.
REQ-030 Changes to req_* while not in IDLE SHALL have no effect.

Reset
REQ-031 Reset SHALL force, asynchronously: state=IDLE, counter=0, rsp_valid=0, rsp_error=0, rsp_rdata=0.
REQ-032 Reset SHALL leave memory contents unchanged.
REQ-033 Reset asserted in WAIT SHALL abort the request; no memory write SHALL occur from an aborted store.
REQ-034 Reset asserted in RESP SHALL drop the pending response.
REQ-035 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-036 Word store then load (WAIT_STATES=2): store addr 0x10, data 0xDEADBEEF, size 10. Expected: rsp_valid 4 cycles after acceptance, error 0. Then load the same address: rsp_rdata=0xDEADBEEF.
REQ-037 Byte store and sign-extended load: store byte 0x80 at addr 0x13 into a word holding 0x00000000. Loading word 0x10 returns 0x80000000. Byte load at 0x13 with unsigned=0 returns 0xFFFFFF80; with unsigned=1 returns 0x00000080.
REQ-038 Misaligned and out-of-range requests: half load at 0x21 → rsp_error=1, rsp_rdata=0, latency 1 cycle, memory unchanged. Word load at 0x1000 with DEPTH_WORDS=1024 → rsp_error=1.
REQ-039 Response backpressure: hold rsp_ready=0 for 5 cycles in RESP. Expected: rsp_valid and rsp_rdata stable throughout, req_ready=0 throughout. After rsp_ready=1, req_ready=1 on the next cycle.
REQ-040 Reset mid-operation: assert reset in the 1st WAIT cycle of a store of 0x12345678 to 0x40, where 0x40 holds 0xCAFEF00D. Expected: outputs return to reset values immediately; a subsequent load from 0x40 returns 0xCAFEF00D.
